// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low hex keypad, debounces whole-matrix
// snapshots and shifts each accepted key into a 32-bit value at the LSB end.
// Optional feature: define KEYPAD_ROW_SYNC_EN to pass the row pins through a
// two-flop synchronizer (reset to 4'b1111) before they are sampled.

module keypad_scanner #(
  parameter int unsigned SCAN_DIV = 2048,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic [31:0] data,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [3:0]  entered
);

  localparam int unsigned DivW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
  localparam logic [3:0] DebCnt   = 4'(DEBOUNCE);
  localparam logic [3:0] EntMax   = 4'd8;

  typedef enum logic [1:0] {
    StIdle,
    StConfirm,
    StHeld
  } state_e;

  // --------------------------------------------------------------------------
  // Column scan timing
  // --------------------------------------------------------------------------
  logic [DivW-1:0] div_q, div_d;
  logic [1:0]      col_idx_q, col_idx_d;
  logic            sample_en;
  logic            scan_end;

  assign sample_en = (div_q == DivLast);
  assign scan_end  = sample_en && (col_idx_q == 2'd3);

  // Divider wraps every SCAN_DIV cycles and steps the column on the wrap.
  always_comb begin
    div_d     = div_q + 1'b1;
    col_idx_d = col_idx_q;
    if (sample_en) begin
      div_d     = '0;
      col_idx_d = col_idx_q + 2'd1;
    end
  end

  // Divider and column index registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q     <= '0;
      col_idx_q <= 2'd0;
    end else begin
      div_q     <= div_d;
      col_idx_q <= col_idx_d;
    end
  end

  // Active-low one-hot column drive decoded from the column index.
  always_comb begin
    col = 4'b1111;
    col[col_idx_q] = 1'b0;
  end

  // --------------------------------------------------------------------------
  // Row input path
  // --------------------------------------------------------------------------
  logic [3:0] row_s;

`ifdef KEYPAD_ROW_SYNC_EN
  logic [3:0] row_meta_q;
  logic [3:0] row_sync_q;

  // Two-flop synchronizer; idles at "no key" so reset never fakes a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_meta_q <= 4'b1111;
      row_sync_q <= 4'b1111;
    end else begin
      row_meta_q <= row;
      row_sync_q <= row_meta_q;
    end
  end

  assign row_s = row_sync_q;
`else
  assign row_s = row;
`endif

  // --------------------------------------------------------------------------
  // Snapshot capture and classification
  // --------------------------------------------------------------------------
  logic [15:0] snap_q, snap_d;
  logic [15:0] snap_now;
  logic [4:0]  key_cnt;
  logic [3:0]  key_idx;
  logic        is_none;
  logic        is_single;

  // snap_now merges the current column's rows into the stored snapshot, so at
  // scan end it is the complete 16-key picture without waiting another cycle.
  always_comb begin
    snap_now = snap_q;
    for (int r = 0; r < 4; r++) begin
      snap_now[{2'(r), col_idx_q}] = ~row_s[r];
    end
    snap_d = sample_en ? snap_now : snap_q;
  end

  // Snapshot register; each scan overwrites every column, so no clear needed.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_q <= '0;
    end else begin
      snap_q <= snap_d;
    end
  end

  // Count pressed keys and remember the index; index only matters when single.
  always_comb begin
    key_cnt = 5'd0;
    key_idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (snap_now[i]) begin
        key_cnt = key_cnt + 5'd1;
        key_idx = 4'(i);
      end
    end
    is_none   = (key_cnt == 5'd0);
    is_single = (key_cnt == 5'd1);
  end

  // --------------------------------------------------------------------------
  // Debounce FSM
  // --------------------------------------------------------------------------
  state_e     state_q, state_d;
  logic [3:0] cand_q, cand_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] rel_q, rel_d;
  logic       accept;
  logic [3:0] acc_code;

  // Next-state logic; only scan-end cycles can move the FSM.
  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    rel_d    = rel_q;
    accept   = 1'b0;
    acc_code = cand_q;
    if (scan_end) begin
      unique case (state_q)
        StIdle: begin
          if (is_single) begin
            cand_d = key_idx;
            if (DebCnt == 4'd1) begin
              accept   = 1'b1;
              acc_code = key_idx;
              rel_d    = 4'd0;
              state_d  = StHeld;
            end else begin
              cnt_d   = 4'd1;
              state_d = StConfirm;
            end
          end
        end
        StConfirm: begin
          if (is_single && (key_idx == cand_q)) begin
            cnt_d = cnt_q + 4'd1;
            if ((cnt_q + 4'd1) == DebCnt) begin
              accept   = 1'b1;
              acc_code = cand_q;
              rel_d    = 4'd0;
              state_d  = StHeld;
            end
          end else begin
            state_d = StIdle;
          end
        end
        StHeld: begin
          // Any key activity, even a different or multi press, restarts release.
          if (is_none) begin
            if ((rel_q + 4'd1) == DebCnt) begin
              rel_d   = 4'd0;
              state_d = StIdle;
            end else begin
              rel_d = rel_q + 4'd1;
            end
          end else begin
            rel_d = 4'd0;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // FSM state and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cand_q  <= 4'd0;
      cnt_q   <= 4'd0;
      rel_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      rel_q   <= rel_d;
    end
  end

  // --------------------------------------------------------------------------
  // Accepted-key outputs
  // --------------------------------------------------------------------------
  logic [31:0] data_q, data_d;
  logic [3:0]  key_code_q, key_code_d;
  logic [3:0]  entered_q, entered_d;
  logic        key_valid_q, key_valid_d;

  // An accept updates all outputs in the same cycle, one cycle after scan end.
  always_comb begin
    data_d      = data_q;
    key_code_d  = key_code_q;
    entered_d   = entered_q;
    key_valid_d = accept;
    if (accept) begin
      data_d     = {data_q[27:0], acc_code};
      key_code_d = acc_code;
      if (entered_q != EntMax) begin
        entered_d = entered_q + 4'd1;
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q      <= '0;
      key_code_q  <= 4'd0;
      entered_q   <= 4'd0;
      key_valid_q <= 1'b0;
    end else begin
      data_q      <= data_d;
      key_code_q  <= key_code_d;
      entered_q   <= entered_d;
      key_valid_q <= key_valid_d;
    end
  end

  assign data      = data_q;
  assign key_code  = key_code_q;
  assign entered   = entered_q;
  assign key_valid = key_valid_q;

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 active-low hex keypad and turns debounced key presses into a 32-bit hex value. Each accepted key is one nibble shifted in at the LSB end. This is the input counterpart of the 8-digit seven-segment display driver: its `data` output feeds the display's 32-bit data input directly, so typed digits scroll in from the right. The block is a board-level front-end that sits between the keypad pins and the core.

## Interface

Parameters:
- `SCAN_DIV`, default 2048: clock cycles each column is driven; must be ≥ 4.
- `DEBOUNCE`, default 4: consecutive full scans a state must persist to be accepted; range 1–15.

Ports:
- `clk` input 1: sole clock; everything is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `row` input 4: keypad row lines, active-low, externally pulled up.
- `col` output 4: keypad column drive, active-low one-hot.
- `data` output 32: entered value; newest nibble in `data[3:0]`.
- `key_valid` output 1: one-cycle pulse per accepted key.
- `key_code` output 4: code of the last accepted key.
- `entered` output 4: count of accepted keys, saturating at 8.

## Operation

Reset values:
- `col` = 4'b1110.
- `data` = 0, `key_code` = 0, `entered` = 0, `key_valid` = 0.
- Divider and column index = 0; FSM in IDLE.

Column scan:
- Column index `c` advances 0→1→2→3→0, moving every `SCAN_DIV` cycles.
- `col[c]` is low; the other three columns are high.

Sampling:
- Rows are sampled on the last cycle of each column slot (divider == `SCAN_DIV`-1).
- A low `row[r]` during column `c` means key code = r*4 + c.
- The sample on slot 3 completes a 16-bit snapshot; that cycle is "scan end".

Snapshot classification at scan end:
- No key down: NONE.
- Exactly one key down: SINGLE(code).
- Two or more keys down: MULTI. MULTI is never accepted.

FSM, evaluated only at scan end:
- IDLE:
  - SINGLE → CONFIRM, candidate = code, counter = 1.
  - If `DEBOUNCE` = 1, accept immediately and go to HELD.
- CONFIRM:
  - SINGLE with the same code → counter+1; when counter reaches `DEBOUNCE`, accept and go to HELD.
  - Any other snapshot → IDLE.
- HELD:
  - NONE → release counter+1; when it reaches `DEBOUNCE`, go to IDLE.
  - SINGLE or MULTI → release counter = 0.
  - Holding a key never generates further accepts.
- Accept performs all of the following together:
  - `data` ← {`data[27:0]`, code}.
  - `key_code` ← code.
  - `entered` ← min(`entered`+1, 8).
  - Pulse `key_valid`.
- Oldest nibble `data[31:28]` is discarded on overflow; no wrap of `entered`.

Reset mid-operation:
- All state returns to reset values on the next edge.
- A pending CONFIRM is dropped; no `key_valid` is produced.

## Timing

- Full scan period = 4·`SCAN_DIV` cycles.
- Accept decision is made in scan-end cycle E. `key_valid`, `data`, `key_code` and `entered` all change in cycle E+1, together.
- `key_valid` is high for exactly cycle E+1.
- Press-to-`key_valid` latency: between (`DEBOUNCE`-1)·4·`SCAN_DIV`+1 and `DEBOUNCE`·4·`SCAN_DIV`+1 cycles after the key is stable, plus synchronizer delay when that is enabled.
- Minimum spacing between two accepts: 2·`DEBOUNCE` scans.
- `col` changes on the edge after the sample cycle of the previous slot.

## Configuration

- `KEYPAD_ROW_SYNC_EN` defined:
  - `row` passes through a two-flop synchronizer, reset to 4'b1111, before sampling.
  - The sampled value reflects the pins 2 cycles earlier.
  - `SCAN_DIV` ≥ 4 guarantees the value sampled belongs to the current column.
- Not defined: `row` is sampled directly on the sample cycle, with no added latency.

## Test plan

All cases use `SCAN_DIV`=4, `DEBOUNCE`=2, macro defined unless stated.

- Press row1/col2 steadily → exactly one `key_valid`; `key_code`=6, `data`=0x00000006, `entered`=1.
- Enter keys 1,2,…,9, each press and release held ≥ 3 scans → nine pulses; `data`=0x23456789, `entered`=8.
- Key 5 present for 1 scan only, then released → no `key_valid`; FSM back in IDLE; `data` unchanged.
- Keys 0 and 5 held together for 10 scans → no pulse. Then hold key 5 alone for 20 scans → one pulse. Release for 1 scan and re-press → no pulse. Release for 2 scans and re-press → second pulse, `data`=0x00000055.
- Assert `rst` for 1 cycle while in CONFIRM for key A → next cycle `col`=1110, `data`=0, `entered`=0; no pulse follows unless the key is re-confirmed for a full 2 scans.
- Without macro: a row edge arriving 1 cycle before the sample is captured. With macro: the same edge is not seen until the next visit to that column.
